// File: rtl/uart_chk_pkg.sv
// -----------------------------------------------------------------------------
// uart_chk_pkg
//   Shared types and helpers for the UART frame checker.
//   - chk_state_e  : receive/compare FSM states
//   - bits_for()   : counter width needed to hold 0..max_val
//   - chk_result_t : one compare result (pulses plus the two data words)
// -----------------------------------------------------------------------------
package uart_chk_pkg;

  // Widest frame the checker supports; result words are stored at this width.
  localparam int MAX_DATA_W = 9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    CMP,
    WAIT_HIGH
  } chk_state_e;

  // Width of a counter that must hold every value in 0..max_val (minimum 1).
  function automatic int bits_for(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  typedef struct packed {
    logic                  match;
    logic                  mismatch;
    logic                  framing_err;
    logic [MAX_DATA_W-1:0] exp;
    logic [MAX_DATA_W-1:0] got;
  } chk_result_t;

endpackage

// File: rtl/uart_frame_checker_if.sv
// -----------------------------------------------------------------------------
// uart_frame_checker_if
//   Signal bundle between the environment (master) and the frame checker
//   (slave).
//   master drives : baud_tick, send_ack, din, tx
//   slave drives  : match, mismatch, framing_err, overflow,
//                   exp_data, got_data, pass_cnt, err_cnt
// -----------------------------------------------------------------------------
interface uart_frame_checker_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) ();

  logic              baud_tick;
  logic              send_ack;
  logic [DATA_W-1:0] din;
  logic              tx;

  logic              match;
  logic              mismatch;
  logic              framing_err;
  logic              overflow;
  logic [DATA_W-1:0] exp_data;
  logic [DATA_W-1:0] got_data;
  logic [CNT_W-1:0]  pass_cnt;
  logic [CNT_W-1:0]  err_cnt;

  modport master (
    output baud_tick, send_ack, din, tx,
    input  match, mismatch, framing_err, overflow,
    input  exp_data, got_data, pass_cnt, err_cnt
  );

  modport slave (
    input  baud_tick, send_ack, din, tx,
    output match, mismatch, framing_err, overflow,
    output exp_data, got_data, pass_cnt, err_cnt
  );

endinterface

// File: rtl/uart_chk_fifo.sv
// -----------------------------------------------------------------------------
// uart_chk_fifo
//   DEPTH x DATA_W FIFO of words the transmitter has accepted, oldest first.
//   A push while full is accepted only if a pop happens in the same cycle;
//   otherwise it is dropped and flagged on 'overflow' (combinational).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   push/wdata : write request and data
//   pop        : read request (ignored when empty)
//   rdata      : oldest word (valid when !empty)
//   empty      : FIFO holds no words
//   overflow   : this cycle's push was dropped
// -----------------------------------------------------------------------------
module uart_chk_fifo
  import uart_chk_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              empty,
  output logic              overflow
);

  localparam int PTR_W   = bits_for(DEPTH - 1);
  localparam int COUNT_W = bits_for(DEPTH);

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [COUNT_W-1:0] count;
  logic               full;
  logic               pop_ok;
  logic               push_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == COUNT_W'(DEPTH));
  assign pop_ok   = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO fits.
  assign push_ok  = push && (!full || pop_ok);
  assign overflow = push && !push_ok;
  assign rdata    = mem[rd_ptr];

  // NOTE: storage is deliberately left out of reset; 'count' alone decides
  // which entries are valid, and an unreset array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_frame_checker.sv
// -----------------------------------------------------------------------------
// uart_frame_checker
//   Monitors a UART transmitter: words accepted on send_ack are queued as
//   expected data, the serial tx line is deserialised independently using an
//   oversampling tick, and each received frame is compared with the oldest
//   expected word.
//
// Optional build macro: UART_CHK_PARITY_EN
//   Adds parameter PARITY_ODD and a parity bit between data and stop bits.
//   A wrong parity bit turns an otherwise equal compare into a mismatch.
//
// Ports:
//   clk          : system clock
//   rst          : synchronous active-high reset
//   bus (slave)  : baud_tick, send_ack, din, tx in;
//                  match, mismatch, framing_err, overflow (1-clk pulses),
//                  exp_data/got_data (last compare), pass_cnt/err_cnt
//                  (saturating) out
// -----------------------------------------------------------------------------
module uart_frame_checker
  import uart_chk_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int OVS       = 16,
  parameter int DEPTH     = 4,
  parameter int STOP_BITS = 1,
  parameter int CNT_W     = 16
`ifdef UART_CHK_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input logic                clk,
  input logic                rst,
  uart_frame_checker_if.slave bus
);

  localparam int TICK_W = bits_for(OVS - 1);
  localparam int BIT_W  = bits_for(DATA_W - 1);
  localparam int STOP_W = bits_for(STOP_BITS - 1);

  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVS / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVS - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_BITS - 1);

  // ---------------------------------------------------------------------------
  // tx synchroniser; resets to the idle level so reset never looks like a start
  // ---------------------------------------------------------------------------
  logic tx_meta;
  logic tx_sync;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others (the two stages stay two stages).
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_meta <= 1'b1;
      tx_sync <= 1'b1;
    end else begin
      tx_meta <= bus.tx;
      tx_sync <= tx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Expected-word FIFO
  // ---------------------------------------------------------------------------
  chk_state_e        state;
  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_empty;
  logic              fifo_overflow;

  uart_chk_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (bus.send_ack),
    .wdata    (bus.din),
    .pop      (fifo_pop),
    .rdata    (fifo_rdata),
    .empty    (fifo_empty),
    .overflow (fifo_overflow)
  );

  // The compare state consumes the oldest word whenever one is queued.
  assign fifo_pop = (state == CMP) && !fifo_empty;

  // ---------------------------------------------------------------------------
  // Receive / compare FSM
  // ---------------------------------------------------------------------------
  logic [TICK_W-1:0] tick_cnt;
  logic [BIT_W-1:0]  bit_idx;
  logic [STOP_W-1:0] stop_idx;
  logic [DATA_W-1:0] shift;
  logic              frame_ok;
  chk_result_t       res;
  logic              overflow_q;

`ifdef UART_CHK_PARITY_EN
  logic parity_ok;
  assign frame_ok = (shift == fifo_rdata) && parity_ok;
`else
  assign frame_ok = (shift == fifo_rdata);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_idx    <= '0;
      stop_idx   <= '0;
      shift      <= '0;
      res        <= '0;
      overflow_q <= 1'b0;
`ifdef UART_CHK_PARITY_EN
      parity_ok  <= 1'b1;
`endif
    end else begin
      // Result flags are single-cycle pulses unless set below.
      res.match       <= 1'b0;
      res.mismatch    <= 1'b0;
      res.framing_err <= 1'b0;
      overflow_q      <= fifo_overflow;

      case (state)
        IDLE: begin
          if (!tx_sync) begin
            state    <= START;
            tick_cnt <= '0;
          end
        end

        // Re-check mid start bit; a high level here was only a glitch.
        START: begin
          if (bus.baud_tick) begin
            if (tick_cnt == HALF_LAST) begin
              tick_cnt <= '0;
              if (tx_sync) begin
                state <= IDLE;
              end else begin
                state   <= DATA;
                bit_idx <= '0;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        // From mid start bit, every OVS ticks lands mid data bit; LSB first.
        DATA: begin
          if (bus.baud_tick) begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt <= '0;
              shift    <= {tx_sync, shift[DATA_W-1:1]};
              if (bit_idx == BIT_LAST) begin
                stop_idx <= '0;
`ifdef UART_CHK_PARITY_EN
                state    <= PARITY;
`else
                state    <= STOP;
`endif
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

`ifdef UART_CHK_PARITY_EN
        // Even parity: data ones plus parity bit is even; odd: it is odd.
        PARITY: begin
          if (bus.baud_tick) begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt  <= '0;
              parity_ok <= ((^shift) ^ tx_sync) == PARITY_ODD;
              state     <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
`endif

        STOP: begin
          if (bus.baud_tick) begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt <= '0;
              if (!tx_sync) begin
                res.framing_err <= 1'b1;
                state           <= WAIT_HIGH;
              end else if (stop_idx == STOP_LAST) begin
                state <= CMP;
              end else begin
                stop_idx <= stop_idx + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        // One clock after the last stop sample; no tick needed.
        CMP: begin
          res.got <= MAX_DATA_W'(shift);
          if (fifo_empty) begin
            res.exp      <= '0;
            res.mismatch <= 1'b1;
          end else begin
            res.exp <= MAX_DATA_W'(fifo_rdata);
            if (frame_ok) res.match    <= 1'b1;
            else          res.mismatch <= 1'b1;
          end
          state <= IDLE;
        end

        // A stuck-low line after a bad stop bit must not be read as a start.
        WAIT_HIGH: begin
          if (tx_sync) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating counters, stepped by the registered pulses
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      pass_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (res.match && (pass_cnt != '1)) pass_cnt <= pass_cnt + 1'b1;
      // Coinciding error pulses count once.
      if ((res.mismatch || res.framing_err || overflow_q) && (err_cnt != '1))
        err_cnt <= err_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.match       = res.match;
  assign bus.mismatch    = res.mismatch;
  assign bus.framing_err = res.framing_err;
  assign bus.overflow    = overflow_q;
  assign bus.exp_data    = res.exp[DATA_W-1:0];
  assign bus.got_data    = res.got[DATA_W-1:0];
  assign bus.pass_cnt    = pass_cnt;
  assign bus.err_cnt     = err_cnt;

  // Result words are stored at the package's maximum width; upper bits idle.
  logic unused_res_bits;
  assign unused_res_bits = ^{res.exp, res.got};

endmodule

// File: tb/tb_uart_frame_checker.sv
module tb_uart_frame_checker;

  localparam int DATA_W    = 8;
  localparam int OVS       = 16;
  localparam int DEPTH     = 4;
  localparam int STOP_BITS = 1;
  localparam int CNT_W     = 4;   // small so pass_cnt saturation is reached
  localparam int TICK_CLKS = 2;
  localparam int BIT_CLKS  = OVS * TICK_CLKS;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_frame_checker_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  uart_frame_checker #(
    .DATA_W    (DATA_W),
    .OVS       (OVS),
    .DEPTH     (DEPTH),
    .STOP_BITS (STOP_BITS),
    .CNT_W     (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    bus.baud_tick = 1'b0;
    forever begin
      @(posedge clk); #1 bus.baud_tick = 1'b1;
      @(posedge clk); #1 bus.baud_tick = 1'b0;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Checking infrastructure
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic              m;
    logic              mm;
    logic              fe;
    logic              ov;
    logic [DATA_W-1:0] e;
    logic [DATA_W-1:0] g;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 &&
        (bus.match || bus.mismatch || bus.framing_err || bus.overflow))
      obs_q.push_back({bus.match, bus.mismatch, bus.framing_err, bus.overflow,
                       bus.exp_data, bus.got_data});
  end

  // ---------------------------------------------------------------------------
  // Reference model: a plain queue of expected words and two integer counters
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] model_q[$];
  int model_pass = 0;
  int model_err  = 0;

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  task automatic model_push(input logic [DATA_W-1:0] d);
    ev_t ev;
    if (model_q.size() == DEPTH) begin
      ev = '0;
      ev.ov = 1'b1;
      exp_q.push_back(ev);
      model_err = sat_inc(model_err);
    end else begin
      model_q.push_back(d);
    end
  endtask

  task automatic model_frame(input logic [DATA_W-1:0] d, input bit stop_ok, input bit par_ok);
    ev_t ev;
    logic [DATA_W-1:0] w;
    ev = '0;
    if (!stop_ok) begin
      ev.fe = 1'b1;
      model_err = sat_inc(model_err);
    end else if (model_q.size() == 0) begin
      ev.mm = 1'b1;
      ev.g  = d;
      model_err = sat_inc(model_err);
    end else begin
      w = model_q.pop_front();
      ev.e = w;
      ev.g = d;
      if (w == d && par_ok) begin
        ev.m = 1'b1;
        model_pass = sat_inc(model_pass);
      end else begin
        ev.mm = 1'b1;
        model_err = sat_inc(model_err);
      end
    end
    exp_q.push_back(ev);
  endtask

  // ---------------------------------------------------------------------------
  // Drivers (all return #1 after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic do_push(input logic [DATA_W-1:0] d);
    bus.send_ack = 1'b1;
    bus.din      = d;
    @(posedge clk); #1;
    bus.send_ack = 1'b0;
    model_push(d);
  endtask

  task automatic send_bit(input logic b);
    bus.tx = b;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input bit stop_ok,
                            input bit bad_par, input int hold_low);
    send_bit(1'b0);
    for (int i = 0; i < DATA_W; i++) send_bit(d[i]);
`ifdef UART_CHK_PARITY_EN
    send_bit((^d) ^ bad_par);
`else
    if (bad_par) bus.tx = 1'b1;
`endif
    for (int i = 0; i < STOP_BITS; i++) send_bit(stop_ok);
    if (!stop_ok) repeat (hold_low) send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
  endtask

  task automatic wait_obs(input int n);
    int budget = 0;
    while (obs_q.size() < n && budget < 4 * BIT_CLKS) begin
      @(posedge clk);
      budget++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Compare observed events and counters with the model, then clear both.
  task automatic settle_events(input string name);
    int n;
    wait_obs(exp_q.size());
    check({name, " event count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s ev%0d kind", name, i),
            {obs_q[i].m, obs_q[i].mm, obs_q[i].fe, obs_q[i].ov},
            {exp_q[i].m, exp_q[i].mm, exp_q[i].fe, exp_q[i].ov});
      if (exp_q[i].m || exp_q[i].mm) begin
        check($sformatf("%s ev%0d exp_data", name, i), obs_q[i].e, exp_q[i].e);
        check($sformatf("%s ev%0d got_data", name, i), obs_q[i].g, exp_q[i].g);
      end
    end
    check({name, " pass_cnt"}, bus.pass_cnt, model_pass);
    check({name, " err_cnt"},  bus.err_cnt,  model_err);
    obs_q.delete();
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    bit                do_push;
    logic [DATA_W-1:0] push_d;
    logic [DATA_W-1:0] frame_d;
    bit                exp_match;
    logic [DATA_W-1:0] exp_e;
    logic [DATA_W-1:0] exp_g;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [DATA_W-1:0] d;
    bit stop_ok;
    int npush;

    vecs[0] = '{1'b1, 8'hA5, 8'hA5, 1'b1, 8'hA5, 8'hA5};
    vecs[1] = '{1'b1, 8'h3C, 8'h3D, 1'b0, 8'h3C, 8'h3D};
    vecs[2] = '{1'b1, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00};
    vecs[3] = '{1'b1, 8'hFF, 8'hFF, 1'b1, 8'hFF, 8'hFF};
    vecs[4] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h80, 8'h01};
    vecs[5] = '{1'b0, 8'h00, 8'h5A, 1'b0, 8'h00, 8'h5A};
    vecs[6] = '{1'b1, 8'h96, 8'h96, 1'b1, 8'h96, 8'h96};

    bus.send_ack = 1'b0;
    bus.din      = '0;
    bus.tx       = 1'b1;
    rst          = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("reset match",       bus.match,       0);
    check("reset mismatch",    bus.mismatch,    0);
    check("reset framing_err", bus.framing_err, 0);
    check("reset overflow",    bus.overflow,    0);
    check("reset exp_data",    bus.exp_data,    0);
    check("reset got_data",    bus.got_data,    0);
    check("reset pass_cnt",    bus.pass_cnt,    0);
    check("reset err_cnt",     bus.err_cnt,     0);

    // Table-driven frames
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].do_push) do_push(vecs[i].push_d);
      send_frame(vecs[i].frame_d, 1'b1, 1'b0, 0);
      model_frame(vecs[i].frame_d, 1'b1, 1'b1);
      wait_obs(1);
      check($sformatf("vec%0d event count", i), obs_q.size(), 1);
      if (obs_q.size() > 0) begin
        check($sformatf("vec%0d match", i),    obs_q[0].m,  vecs[i].exp_match);
        check($sformatf("vec%0d mismatch", i), obs_q[0].mm, !vecs[i].exp_match);
        check($sformatf("vec%0d exp_data", i), obs_q[0].e,  vecs[i].exp_e);
        check($sformatf("vec%0d got_data", i), obs_q[0].g,  vecs[i].exp_g);
      end
      check($sformatf("vec%0d pass_cnt", i), bus.pass_cnt, model_pass);
      check($sformatf("vec%0d err_cnt", i),  bus.err_cnt,  model_err);
      obs_q.delete();
      exp_q.delete();
    end

    // Overflow: five pushes into a 4-deep FIFO, then four matching frames
    for (int i = 1; i <= 5; i++) do_push(DATA_W'(i * 16));
    settle_events("overflow");
    for (int i = 1; i <= 4; i++) begin
      send_frame(DATA_W'(i * 16), 1'b1, 1'b0, 0);
      model_frame(DATA_W'(i * 16), 1'b1, 1'b1);
      settle_events($sformatf("drain%0d", i));
    end

    // Framing error, line held low three bit-times, word must still be queued
    do_push(8'h55);
    send_frame(8'h55, 1'b0, 1'b0, 3);
    model_frame(8'h55, 1'b0, 1'b1);
    settle_events("framing");
    send_frame(8'h55, 1'b1, 1'b0, 0);
    model_frame(8'h55, 1'b1, 1'b1);
    settle_events("after framing");

    // Start-bit glitch of OVS/4 ticks: no event, queued word untouched
    do_push(8'hC3);
    bus.tx = 1'b0;
    repeat ((OVS / 4) * TICK_CLKS) @(posedge clk);
    #1 bus.tx = 1'b1;
    repeat (3 * BIT_CLKS) @(posedge clk);
    #1;
    settle_events("glitch");
    send_frame(8'hC3, 1'b1, 1'b0, 0);
    model_frame(8'hC3, 1'b1, 1'b1);
    settle_events("after glitch");

    // Reset in the middle of a data bit abandons the frame and the queue
    do_push(8'h11);
    do_push(8'h22);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    bus.tx = 1'b1;
    repeat (BIT_CLKS / 2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_q.delete();
    obs_q.delete();
    exp_q.delete();
    model_pass = 0;
    model_err  = 0;
    check("midreset pass_cnt", bus.pass_cnt, 0);
    check("midreset err_cnt",  bus.err_cnt,  0);
    repeat (2 * BIT_CLKS) @(posedge clk);
    #1;
    settle_events("midreset quiet");
    do_push(8'h99);
    send_frame(8'h99, 1'b1, 1'b0, 0);
    model_frame(8'h99, 1'b1, 1'b1);
    settle_events("after midreset");

    // Randomised traffic against the model (also drives pass_cnt to saturation)
    for (int it = 0; it < 40; it++) begin
      npush = $urandom_range(0, 2);
      for (int k = 0; k < npush; k++) do_push(DATA_W'($urandom));
      if (model_q.size() > 0 && $urandom_range(0, 3) != 0) d = model_q[0];
      else d = DATA_W'($urandom);
      stop_ok = ($urandom_range(0, 7) != 0);
      send_frame(d, stop_ok, 1'b0, 0);
      model_frame(d, stop_ok, 1'b1);
      settle_events($sformatf("rnd%0d", it));
    end

`ifdef UART_CHK_PARITY_EN
    // Even parity: 0x07 needs parity bit 1
    model_q.delete();
    do_push(8'h07);
    send_frame(8'h07, 1'b1, 1'b1, 0);
    model_frame(8'h07, 1'b1, 1'b0);
    settle_events("parity bad");
    do_push(8'h07);
    send_frame(8'h07, 1'b1, 1'b0, 0);
    model_frame(8'h07, 1'b1, 1'b1);
    settle_events("parity good");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
